// File: rtl/ysyx_25040111_mem_arbiter.sv
// Two-master (icache refill / LSU) arbiter onto a single downstream memory port.
// Round-robin on ties; one transaction in flight; at least one idle cycle between transactions.
module ysyx_25040111_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   // icache refill master
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic [7:0]        if_len,
   input  logic              if_burst,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_rvalid,
   output logic              if_done,
   // load/store master
   input  logic              ls_req,
   input  logic              ls_wen,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic [3:0]        ls_wstrb,
   input  logic [2:0]        ls_size,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_done,
   // downstream port; m_valid/m_ready is a plain valid/ready handshake: the request
   // fields are held stable from m_valid rising until the cycle where both are high
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_wen,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [3:0]        m_wstrb,
   output logic [2:0]        m_size,
   output logic [7:0]        m_len,
   output logic              m_burst,
   input  logic              m_rvalid,
   input  logic              m_rlast,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_bvalid,
   input  logic [1:0]        m_resp,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, REQ, RDATA, WRESP} state_t;

   state_t     state;
   logic       gnt_ls;    // current owner: 1 = LSU, 0 = IF
   logic       last_ls;   // most recent grant, for round-robin ties
   logic       cooldown;  // forces the idle cycle after each completion
   logic [7:0] beat_cnt;
   logic       pick_ls;
   logic       if_beat;
   logic       cnt_hit;

   assign pick_ls = ls_req && (!if_req || !last_ls);

   // Refill beats bypass registers so the icache sees data with zero added latency.
   assign if_beat   = (state == RDATA) && !gnt_ls && m_rvalid;
   assign cnt_hit   = (beat_cnt == m_len);
   assign if_rvalid = if_beat;
   assign if_rdata  = m_rdata;
   assign if_done   = if_beat && (m_rlast || cnt_hit);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         gnt_ls   <= 1'b0;
         last_ls  <= 1'b0;
         cooldown <= 1'b0;
         beat_cnt <= 8'd0;
         m_valid  <= 1'b0;
         m_wen    <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_wstrb  <= 4'd0;
         m_size   <= 3'd0;
         m_len    <= 8'd0;
         m_burst  <= 1'b0;
         ls_rdata <= '0;
         ls_done  <= 1'b0;
         err      <= 1'b0;
      end else begin
         ls_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cooldown) begin
                  cooldown <= 1'b0;
               end else if (if_req || ls_req) begin
                  gnt_ls   <= pick_ls;
                  last_ls  <= pick_ls;
                  m_valid  <= 1'b1;
                  beat_cnt <= 8'd0;
                  state    <= REQ;
                  if (pick_ls) begin
                     m_wen   <= ls_wen;
                     m_addr  <= ls_addr;
                     m_wdata <= ls_wdata;
                     m_wstrb <= ls_wstrb;
                     m_size  <= ls_size;
                     m_len   <= 8'd0;
                     m_burst <= 1'b0;
                  end else begin
                     m_wen   <= 1'b0;
                     m_addr  <= if_addr;
                     m_wdata <= '0;
                     m_wstrb <= 4'd0;
                     m_size  <= 3'b010;
                     m_len   <= if_len;
                     m_burst <= if_burst;
                  end
               end
            end
            REQ: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= m_wen ? WRESP : RDATA;
               end
            end
            RDATA: begin
               if (m_rvalid) begin
                  if (m_resp != 2'b00) err <= 1'b1;
                  if (gnt_ls) begin
                     ls_rdata <= m_rdata;
                     ls_done  <= 1'b1;
                     state    <= IDLE;
                     cooldown <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                     if (m_rlast || cnt_hit) begin
                        // Running out of beats without rlast is a protocol error.
                        if (!m_rlast) err <= 1'b1;
                        state    <= IDLE;
                        cooldown <= 1'b1;
                     end
                  end
               end
            end
            WRESP: begin
               if (m_bvalid) begin
                  if (m_resp != 2'b00) err <= 1'b1;
                  ls_done  <= 1'b1;
                  state    <= IDLE;
                  cooldown <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Directed bench for the memory arbiter: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_ysyx_25040111_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [7:0]  if_len;
   logic        if_burst;
   logic [31:0] if_rdata;
   logic        if_rvalid;
   logic        if_done;
   logic        ls_req;
   logic        ls_wen;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_wstrb;
   logic [2:0]  ls_size;
   logic [31:0] ls_rdata;
   logic        ls_done;
   logic        m_valid;
   logic        m_ready;
   logic        m_wen;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic [2:0]  m_size;
   logic [7:0]  m_len;
   logic        m_burst;
   logic        m_rvalid;
   logic        m_rlast;
   logic [31:0] m_rdata;
   logic        m_bvalid;
   logic [1:0]  m_resp;
   logic        err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   ysyx_25040111_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_burst(if_burst),
      .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_done(if_done),
      .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wstrb(ls_wstrb), .ls_size(ls_size), .ls_rdata(ls_rdata), .ls_done(ls_done),
      .m_valid(m_valid), .m_ready(m_ready), .m_wen(m_wen), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_size(m_size), .m_len(m_len),
      .m_burst(m_burst), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata),
      .m_bvalid(m_bvalid), .m_resp(m_resp), .err(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      if_req = 0; if_addr = 0; if_len = 0; if_burst = 0;
      ls_req = 0; ls_wen = 0; ls_addr = 0; ls_wdata = 0; ls_wstrb = 0; ls_size = 0;
      m_ready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = 0; m_bvalid = 0; m_resp = 0;
      tick();
      tick();
      reset = 1'b0;

      // reset values
      chk("rst_m_valid", m_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_ls_done", ls_done, 0);
      chk("rst_ls_rdata", ls_rdata, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_if_done", if_done, 0);

      // single LSU load
      ls_req = 1; ls_wen = 0; ls_addr = 32'h8000_0010; ls_size = 3'd2; m_ready = 1;
      tick();
      chk("ld_m_valid", m_valid, 1);
      chk("ld_m_addr", m_addr, 32'h8000_0010);
      chk("ld_m_wen", m_wen, 0);
      chk("ld_m_len", m_len, 0);
      chk("ld_m_size", m_size, 2);
      tick();
      chk("ld_m_valid_drop", m_valid, 0);
      m_rvalid = 1; m_rdata = 32'h1234_5678; m_rlast = 1;
      #1;
      chk("ld_no_if_rvalid", if_rvalid, 0);
      tick();
      m_rvalid = 0; m_rlast = 0;
      chk("ld_ls_done", ls_done, 1);
      chk("ld_ls_rdata", ls_rdata, 32'h1234_5678);
      ls_req = 0;
      tick();
      chk("ld_ls_done_pulse", ls_done, 0);
      chk("ld_m_valid_idle", m_valid, 0);
      chk("ld_rdata_hold", ls_rdata, 32'h1234_5678);

      // simultaneous requests after reset: LSU first, then IF after an idle cycle
      reset = 1; tick(); reset = 0;
      if_req = 1; if_addr = 32'hA000_0000; if_len = 8'd7; if_burst = 1;
      ls_req = 1; ls_wen = 0; ls_addr = 32'h0000_0100; ls_size = 3'd0;
      tick();
      chk("tie_m_addr_ls", m_addr, 32'h0000_0100);
      chk("tie_m_size_ls", m_size, 0);
      tick();
      m_rvalid = 1; m_rdata = 32'hCAFE_0001; m_rlast = 1;
      tick();
      m_rvalid = 0; m_rlast = 0; ls_req = 0;
      chk("tie_ls_done", ls_done, 1);
      chk("tie_no_regrant", m_valid, 0);
      tick();
      chk("tie_idle_cycle", m_valid, 0);
      tick();
      chk("tie_if_m_valid", m_valid, 1);
      chk("tie_if_m_addr", m_addr, 32'hA000_0000);
      chk("tie_if_m_len", m_len, 7);
      chk("tie_if_m_burst", m_burst, 1);
      chk("tie_if_m_size", m_size, 2);
      chk("tie_if_m_wen", m_wen, 0);

      // 8-beat IF burst
      tick();
      for (int i = 0; i < 8; i++) begin
         m_rvalid = 1; m_rdata = 32'hB000_0000 + i; m_rlast = (i == 7);
         #1;
         chk("burst_rvalid", if_rvalid, 1);
         chk("burst_rdata", if_rdata, 64'hB000_0000 + i);
         chk("burst_done", if_done, (i == 7) ? 64'd1 : 64'd0);
         if (i == 0) chk("burst_no_ls_done", ls_done, 0);
         tick();
      end
      m_rvalid = 0; m_rlast = 0; if_req = 0;
      chk("burst_end_rvalid", if_rvalid, 0);
      chk("burst_err", err, 0);
      tick();

      // store held off by m_ready low for 3 cycles; request lines change meanwhile
      m_ready = 0;
      ls_req = 1; ls_wen = 1; ls_addr = 32'h8000_0020; ls_wdata = 32'hDEAD_BEEF;
      ls_wstrb = 4'hF; ls_size = 3'd2;
      tick();
      ls_addr = 32'h1111_1111; ls_wdata = 32'h2222_2222; ls_wstrb = 4'h3;
      for (int i = 0; i < 3; i++) begin
         chk("st_m_valid", m_valid, 1);
         chk("st_m_wen", m_wen, 1);
         chk("st_m_addr", m_addr, 32'h8000_0020);
         chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
         chk("st_m_wstrb", m_wstrb, 4'hF);
         tick();
      end
      m_ready = 1;
      tick();
      chk("st_m_valid_drop", m_valid, 0);
      m_bvalid = 1; m_resp = 2'b00;
      #1;
      chk("st_ls_done_early", ls_done, 0);
      tick();
      m_bvalid = 0; ls_req = 0;
      chk("st_ls_done", ls_done, 1);
      chk("st_err", err, 0);
      tick();
      chk("st_ls_done_pulse", ls_done, 0);

      // error response on a load beat; err stays sticky across a later IF transaction
      ls_req = 1; ls_wen = 0; ls_addr = 32'h0000_0030;
      tick();
      tick();
      m_rvalid = 1; m_rlast = 1; m_resp = 2'b10; m_rdata = 32'h0000_0055;
      tick();
      m_rvalid = 0; m_rlast = 0; m_resp = 2'b00; ls_req = 0;
      chk("er_err", err, 1);
      chk("er_ls_rdata", ls_rdata, 32'h55);
      tick();
      if_req = 1; if_addr = 32'h0000_0040; if_len = 8'd0; if_burst = 0;
      tick();
      chk("er_if_m_len", m_len, 0);
      chk("er_if_m_burst", m_burst, 0);
      tick();
      m_rvalid = 1; m_rlast = 1; m_rdata = 32'h77;
      #1;
      chk("er_if_done", if_done, 1);
      tick();
      m_rvalid = 0; m_rlast = 0; if_req = 0;
      chk("er_err_sticky", err, 1);
      tick();

      // reset in beat 3 of an IF burst
      if_req = 1; if_addr = 32'hA000_0100; if_len = 8'd7; if_burst = 1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         m_rvalid = 1; m_rdata = 32'hC000_0000 + i;
         tick();
      end
      reset = 1;
      tick();
      reset = 0; if_req = 0;
      chk("mr_if_rvalid", if_rvalid, 0);
      chk("mr_if_done", if_done, 0);
      chk("mr_m_valid", m_valid, 0);
      chk("mr_err", err, 0);
      chk("mr_ls_done", ls_done, 0);
      chk("mr_ls_rdata", ls_rdata, 0);
      tick();
      chk("mr_late_beat", if_rvalid, 0);
      chk("mr_no_grant", m_valid, 0);
      m_rvalid = 0;
      tick();

      // beat count reaches m_len without rlast: terminate and flag
      if_req = 1; if_addr = 32'h0000_0200; if_len = 8'd1; if_burst = 1;
      tick();
      tick();
      m_rvalid = 1; m_rlast = 0; m_rdata = 32'hD0;
      #1;
      chk("ov_done_b0", if_done, 0);
      tick();
      m_rdata = 32'hD1;
      #1;
      chk("ov_done_b1", if_done, 1);
      tick();
      chk("ov_err", err, 1);
      chk("ov_after_rvalid", if_rvalid, 0);
      m_rvalid = 0; if_req = 0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_25040111_mem_arbiter.md
YSYX_25040111_MEM_ARBITER -- requirements
Module: ysyx_25040111_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have the following ports:
  clock  in  1  sole clock; all state updates on rising edge.
  reset  in  1  synchronous, active-high.
  if_req  in  1  icache refill request; level, held until if_done.
  if_addr  in  ADDR_W  refill start address.
  if_len  in  8  burst beats minus 1 (AXI len encoding).
  if_burst  in  1  1 = INCR burst, 0 = single beats.
  if_rdata  out  DATA_W  refill beat data.
  if_rvalid  out  1  beat valid, one cycle per beat.
  if_done  out  1  one-cycle pulse with last beat.
  ls_req  in  1  LSU request; level, held until ls_done.
  ls_wen  in  1  1 = store, 0 = load.
  ls_addr  in  ADDR_W  data address.
  ls_wdata  in  DATA_W  store data.
  ls_wstrb  in  4  byte strobes.
  ls_size  in  3  AXI size.
  ls_rdata  out  DATA_W  load data.
  ls_done  out  1  one-cycle completion pulse.
  m_valid  out  1  downstream request valid.
  m_ready  in  1  downstream accepts request.
  m_wen, m_addr, m_wdata, m_wstrb, m_size, m_len, m_burst  out  1/ADDR_W/DATA_W/4/3/8/1  forwarded request fields.
  m_rvalid  in  1  read beat valid.
  m_rlast  in  1  last read beat.
  m_rdata  in  DATA_W  read beat data.
  m_bvalid  in  1  write response valid.
  m_resp  in  2  response code (RESP/RLAST beats and B).
  err  out  1  sticky error flag.

Function
REQ-004 SHALL implement FSM states IDLE, REQ, RDATA, WRESP; reset state IDLE.
REQ-005 SHALL, in IDLE, grant when either request asserted: only one -> that one; both -> master not granted most recently (round-robin, last-grant register resets to IF so LSU wins first tie).
REQ-006 SHALL latch granted request fields into internal registers on the grant edge and drive m_* only from those registers.
REQ-007 SHALL assert m_valid in REQ state; hold all m_* stable until m_valid&&m_ready.
REQ-008 SHALL transition REQ -> RDATA on handshake for reads, REQ -> WRESP for stores.
REQ-009 SHALL drive m_len=if_len, m_burst=if_burst, m_size=3'b010, m_wen=0 for IF grants; m_len=0, m_burst=0, m_size=ls_size for LSU grants.
REQ-010 SHALL, in RDATA for IF grant, present each m_rvalid beat combinationally on if_rdata/if_rvalid (zero added latency).
REQ-011 SHALL, in RDATA for LSU grant, register m_rdata into ls_rdata and pulse ls_done one cycle after the m_rvalid beat; ls_rdata holds until next LSU load completes.
REQ-012 SHALL count IF beats with 8-bit counter; leave RDATA on m_rvalid&&m_rlast, pulsing if_done in that same cycle; if count reaches m_len without rlast, also terminate and set err.
REQ-013 SHALL, in WRESP, on m_bvalid, pulse ls_done next cycle and return to IDLE.
REQ-014 SHALL return to IDLE after completion and not re-grant in the completion cycle (minimum one idle cycle between transactions).
REQ-015 SHALL set err when m_resp != 2'b00 on any accepted beat or B response; err clears only on reset.
REQ-016 SHALL ignore request-line deassertion mid-transaction; transaction completes as latched.
REQ-017 SHALL keep if_rvalid, if_done, ls_done deasserted while the other master holds the grant.

Reset
REQ-018 SHALL, on reset, force state IDLE, m_valid=0, if_rvalid=0, if_done=0, ls_done=0, ls_rdata=0, err=0, beat counter=0, last-grant=IF, regardless of in-flight transaction; late downstream responses after reset are ignored in IDLE.

Verification
REQ-019 SHALL pass: ls_req load addr 0x8000_0010, m_ready=1, m_rdata=0x1234_5678 one cycle later -> m_valid one cycle, ls_rdata=0x1234_5678, ls_done one pulse.
REQ-020 SHALL pass: if_req and ls_req same cycle after reset -> LSU granted first; IF granted after LSU completion and one idle cycle.
REQ-021 SHALL pass: IF burst if_len=7, addr 0xA000_0000, 8 beats with rlast on 8th -> 8 if_rvalid pulses, if_done coincident with 8th, m_burst=1.
REQ-022 SHALL pass: store with m_ready low 3 cycles -> m_addr/m_wdata/m_wstrb stable throughout; ls_done one cycle after m_bvalid.
REQ-023 SHALL pass: read beat with m_resp=2'b10 -> err=1 and remains 1 through later transactions until reset.
REQ-024 SHALL pass: reset asserted during beat 3 of IF burst -> next cycle state IDLE, all outputs at reset values, subsequent m_rvalid produces no if_rvalid.
